irrigacao_multizona: RTL and testbench

- Sequences a single shared pump across N_ZONAS irrigation zones, each with its own soil sensor, moisture threshold and maximum pump time.
- On each irrigation cycle, visits the zones round-robin and computes each zone's pump time with thermal compensation.
- Opens the zone valve, runs the pump on a millisecond timebase, then closes the valve.
- Enforces a water-level safety interlock with hysteresis; sits between the plant-catalog lookup and the pump/valve drivers.

---
 rtl/irrigacao_multizona.sv | 256 +++++++++++++++++++++++++
 tb/tb_irrigacao_multizona.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigacao_multizona.sv
// Shared-pump irrigation sequencer: visits zones round-robin, sizes each zone's
// pump time from its moisture deficit (with hot-weather boost) and drives valve/pump.
module irrigacao_multizona #(
    parameter int N_ZONAS      = 4,
    parameter int ZW           = 2,
    parameter int CLK_HZ       = 50000000,
    parameter int MS_POR_PONTO = 1000,
    parameter int TEMP_QUENTE  = 35,
    parameter int NIVEL_MIN    = 15,
    parameter int NIVEL_HIST   = 5,
    parameter int T_VALVULA_MS = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ciclo_iniciar,
    input  logic [N_ZONAS-1:0]     zona_habilita,
    input  logic [8*N_ZONAS-1:0]   zona_solo,
    input  logic [8*N_ZONAS-1:0]   zona_umid_min,
    input  logic [16*N_ZONAS-1:0]  zona_tempo_max,
    input  logic [7:0]             sensor_temp,
    input  logic [7:0]             sensor_nivel,
    output logic [N_ZONAS-1:0]     valvula,
    output logic                   bomba_ligada,
    output logic [ZW-1:0]          zona_ativa,
    output logic [15:0]            tempo_restante_ms,
    output logic                   ocupado,
    output logic                   alerta_nivel_baixo,
    output logic                   ciclo_concluido,
    output logic [N_ZONAS-1:0]     zona_abortada
);

    localparam int DIV     = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int VW      = (T_VALVULA_MS > 1) ? $clog2(T_VALVULA_MS) : 1;
    localparam int N_SLOTS = 2 ** ZW;

    typedef enum logic [2:0] {
        OCIOSO,
        AVALIA,
        ABRE,
        IRRIGA,
        FECHA,
        PROXIMA
    } estado_t;

    estado_t estado_reg, estado_next;

    logic [PW-1:0]      presc_reg;
    logic [VW-1:0]      valv_cnt_reg;
    logic [ZW-1:0]      zona_ativa_reg;
    logic [15:0]        tempo_reg;
    logic [N_ZONAS-1:0] abortada_reg;
    logic               alerta_reg;

    logic               tick;
    logic               valv_fim;
    logic               entra_temporizado;
    logic               ultima_zona;
    logic               pula_zona;
    logic [N_ZONAS-1:0] zona_onehot;

    // Per-zone fields unpacked into power-of-two arrays so any zona_ativa value is a legal index
    logic [7:0]  solo_arr     [N_SLOTS];
    logic [7:0]  umid_min_arr [N_SLOTS];
    logic [15:0] tempo_max_arr[N_SLOTS];
    logic        habilita_arr [N_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_zona
            if (gi < N_ZONAS) begin : g_real
                assign solo_arr[gi]      = zona_solo[8*gi +: 8];
                assign umid_min_arr[gi]  = zona_umid_min[8*gi +: 8];
                assign tempo_max_arr[gi] = zona_tempo_max[16*gi +: 16];
                assign habilita_arr[gi]  = zona_habilita[gi];
            end else begin : g_vazia
                assign solo_arr[gi]      = 8'd0;
                assign umid_min_arr[gi]  = 8'd0;
                assign tempo_max_arr[gi] = 16'd0;
                assign habilita_arr[gi]  = 1'b0;
            end
        end
        for (gi = 0; gi < N_ZONAS; gi++) begin : g_onehot
            assign zona_onehot[gi] = (zona_ativa_reg == ZW'(gi));
        end
    endgenerate

    // Pump-time computation; its inputs matter only during the single AVALIA cycle
    logic [7:0]  solo_sel;
    logic [7:0]  umid_min_sel;
    logic [15:0] tempo_max_sel;
    logic [7:0]  deficit;
    logic [23:0] t_base;
    logic [24:0] t_comp;
    logic [15:0] tempo_calc;

    always_comb begin
        solo_sel      = solo_arr[zona_ativa_reg];
        umid_min_sel  = umid_min_arr[zona_ativa_reg];
        tempo_max_sel = tempo_max_arr[zona_ativa_reg];
        deficit       = (solo_sel < umid_min_sel) ? (umid_min_sel - solo_sel) : 8'd0;
        t_base        = 24'(deficit) * 24'(MS_POR_PONTO);
        if (sensor_temp > 8'(TEMP_QUENTE)) begin
            t_comp = {1'b0, t_base} + 25'(t_base >> 2);
        end else begin
            t_comp = {1'b0, t_base};
        end
        tempo_calc = (t_comp > 25'(tempo_max_sel)) ? tempo_max_sel : t_comp[15:0];
    end

    assign pula_zona   = !habilita_arr[zona_ativa_reg] || (tempo_calc == 16'd0) || alerta_reg;
    assign ultima_zona = (zona_ativa_reg == ZW'(N_ZONAS - 1));
    assign tick        = (presc_reg == PW'(DIV - 1));
    assign valv_fim    = tick && (valv_cnt_reg == VW'(T_VALVULA_MS - 1));

    // Restarting the prescaler on entry makes the first ms of every timed state a full ms
    assign entra_temporizado = (estado_next != estado_reg) &&
                               ((estado_next == ABRE) || (estado_next == IRRIGA) ||
                                (estado_next == FECHA));

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg <= OCIOSO;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            OCIOSO: begin
                if (ciclo_iniciar) begin
                    estado_next = AVALIA;
                end
            end
            AVALIA: begin
                estado_next = pula_zona ? PROXIMA : ABRE;
            end
            ABRE: begin
                if (valv_fim) begin
                    estado_next = IRRIGA;
                end
            end
            IRRIGA: begin
                if (alerta_reg) begin
                    estado_next = FECHA;
                end else if (tick && (tempo_reg <= 16'd1)) begin
                    estado_next = FECHA;
                end
            end
            FECHA: begin
                if (valv_fim) begin
                    estado_next = PROXIMA;
                end
            end
            PROXIMA: begin
                estado_next = ultima_zona ? OCIOSO : AVALIA;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    always_comb begin
        valvula         = '0;
        bomba_ligada    = 1'b0;
        ciclo_concluido = 1'b0;
        ocupado         = (estado_reg != OCIOSO);
        case (estado_reg)
            ABRE, FECHA: begin
                valvula = zona_onehot;
            end
            IRRIGA: begin
                valvula      = zona_onehot;
                bomba_ligada = 1'b1;
            end
            PROXIMA: begin
                ciclo_concluido = ultima_zona;
            end
            default: begin
                valvula = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || entra_temporizado || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || entra_temporizado) begin
            valv_cnt_reg <= '0;
        end else if (((estado_reg == ABRE) || (estado_reg == FECHA)) && tick) begin
            valv_cnt_reg <= valv_cnt_reg + VW'(1);
        end
    end

    // Level interlock with hysteresis band [NIVEL_MIN, NIVEL_MIN+NIVEL_HIST)
    always_ff @(posedge clk) begin
        if (rst) begin
            alerta_reg <= 1'b0;
        end else if (sensor_nivel < 8'(NIVEL_MIN)) begin
            alerta_reg <= 1'b1;
        end else if (sensor_nivel >= 8'(NIVEL_MIN + NIVEL_HIST)) begin
            alerta_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zona_ativa_reg <= '0;
            tempo_reg      <= '0;
            abortada_reg   <= '0;
        end else begin
            case (estado_reg)
                OCIOSO: begin
                    if (ciclo_iniciar) begin
                        zona_ativa_reg <= '0;
                        abortada_reg   <= '0;
                    end
                end
                AVALIA: begin
                    tempo_reg <= tempo_calc;
                end
                IRRIGA: begin
                    // An abort keeps the residual time visible for the operator
                    if (alerta_reg) begin
                        abortada_reg <= abortada_reg | zona_onehot;
                    end else if (tick) begin
                        tempo_reg <= tempo_reg - 16'd1;
                    end
                end
                PROXIMA: begin
                    if (!ultima_zona) begin
                        zona_ativa_reg <= zona_ativa_reg + ZW'(1);
                    end
                end
                default: begin
                    tempo_reg <= tempo_reg;
                end
            endcase
        end
    end

    assign zona_ativa         = zona_ativa_reg;
    assign tempo_restante_ms  = tempo_reg;
    assign zona_abortada      = abortada_reg;
    assign alerta_nivel_baixo = alerta_reg;

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench: expected zone services are queued before each cycle and a
// negedge monitor pops and compares them as valves open and close.
module tb_irrigacao_multizona;

    localparam int N  = 4;
    localparam int ZW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ciclo_iniciar;
    logic [N-1:0]      zona_habilita;
    logic [8*N-1:0]    zona_solo;
    logic [8*N-1:0]    zona_umid_min;
    logic [16*N-1:0]   zona_tempo_max;
    logic [7:0]        sensor_temp;
    logic [7:0]        sensor_nivel;
    logic [N-1:0]      valvula;
    logic              bomba_ligada;
    logic [ZW-1:0]     zona_ativa;
    logic [15:0]       tempo_restante_ms;
    logic              ocupado;
    logic              alerta_nivel_baixo;
    logic              ciclo_concluido;
    logic [N-1:0]      zona_abortada;

    irrigacao_multizona #(
        .N_ZONAS(N), .ZW(ZW), .CLK_HZ(1000), .MS_POR_PONTO(1000), .TEMP_QUENTE(35),
        .NIVEL_MIN(15), .NIVEL_HIST(5), .T_VALVULA_MS(2)
    ) dut (
        .clk(clk), .rst(rst), .ciclo_iniciar(ciclo_iniciar), .zona_habilita(zona_habilita),
        .zona_solo(zona_solo), .zona_umid_min(zona_umid_min), .zona_tempo_max(zona_tempo_max),
        .sensor_temp(sensor_temp), .sensor_nivel(sensor_nivel), .valvula(valvula),
        .bomba_ligada(bomba_ligada), .zona_ativa(zona_ativa),
        .tempo_restante_ms(tempo_restante_ms), .ocupado(ocupado),
        .alerta_nivel_baixo(alerta_nivel_baixo), .ciclo_concluido(ciclo_concluido),
        .zona_abortada(zona_abortada)
    );

    always #5 clk = ~clk;

    typedef struct {
        int zona;
        int tempo;
        int bomba;
        int antes;
        int depois;
    } svc_t;

    svc_t     exp_q[$];
    int       checks = 0;
    int       errors = 0;
    int       za_cnt[N];
    logic [N-1:0] mascara;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulso_inicio();
        ciclo_iniciar = 1'b1;
        @(negedge clk);
        ciclo_iniciar = 1'b0;
    endtask

    task automatic limpa_contadores();
        for (int i = 0; i < N; i++) za_cnt[i] = 0;
        mascara = '0;
    endtask

    task automatic espera_ciclo(input int budget, input string tag);
        int n = 0;
        while (ciclo_concluido !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
        $display("cycle %s done after %0d cycles", tag, n);
        @(negedge clk);
        chk({tag, "_pulso"}, 32'(ciclo_concluido), 0);
        chk({tag, "_ocioso"}, 32'(ocupado), 0);
    endtask

    task automatic espera_bomba(input logic nivel, input int budget, input string tag);
        int n = 0;
        while (bomba_ligada !== nivel && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    // Service monitor: measures valve lead, pump duration and valve trail per zone
    initial begin
        bit em_servico = 0;
        bit viu_bomba  = 0;
        int zona_srv = 0, tempo_abre = 0, n_bomba = 0, n_antes = 0, n_depois = 0;
        svc_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                em_servico = 0;
            end else begin
                chk("valvula_onehot", 32'($onehot0(valvula)), 1);
                if (bomba_ligada) chk("bomba_sem_valvula", 32'(valvula != '0), 1);
                if (ocupado) za_cnt[zona_ativa]++;
                mascara = mascara | valvula;
                if (valvula != '0) begin
                    if (!em_servico) begin
                        em_servico = 1;
                        viu_bomba  = 0;
                        tempo_abre = int'(tempo_restante_ms);
                        n_bomba = 0; n_antes = 0; n_depois = 0;
                        for (int i = 0; i < N; i++) if (valvula[i]) zona_srv = i;
                    end
                    if (bomba_ligada) begin
                        n_bomba++;
                        viu_bomba = 1;
                    end else if (!viu_bomba) begin
                        n_antes++;
                    end else begin
                        n_depois++;
                    end
                end else if (em_servico) begin
                    em_servico = 0;
                    chk("servico_esperado", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        $display("service zone %0d tempo %0d pump %0d lead %0d trail %0d",
                                 zona_srv, tempo_abre, n_bomba, n_antes, n_depois);
                        chk("srv_zona", zona_srv, e.zona);
                        chk("srv_tempo", tempo_abre, e.tempo);
                        chk("srv_bomba", n_bomba, e.bomba);
                        chk("srv_antes", n_antes, e.antes);
                        chk("srv_depois", n_depois, e.depois);
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        ciclo_iniciar  = 1'b0;
        zona_habilita  = 4'b0111;
        // zone3 50/50/30000, zone2 10/60/20000, zone1 25/10/30000, zone0 25/40/30000
        zona_solo      = {8'd50, 8'd10, 8'd25, 8'd25};
        zona_umid_min  = {8'd50, 8'd60, 8'd10, 8'd40};
        zona_tempo_max = {16'd30000, 16'd20000, 16'd30000, 16'd30000};
        sensor_temp    = 8'd25;
        sensor_nivel   = 8'd10;
        limpa_contadores();

        repeat (3) @(negedge clk);
        chk("rst_valvula", 32'(valvula), 0);
        chk("rst_bomba", 32'(bomba_ligada), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_tempo", 32'(tempo_restante_ms), 0);
        chk("rst_alerta", 32'(alerta_nivel_baixo), 0);
        chk("rst_abortada", 32'(zona_abortada), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("alerta_pos_rst", 32'(alerta_nivel_baixo), 1);
        sensor_nivel = 8'd80;
        @(negedge clk);
        chk("alerta_limpa_80", 32'(alerta_nivel_baixo), 0);

        // Cycle A: zone0 15000 ms, zone1 skipped, zone2 clamped to 20000, zone3 disabled
        exp_q.push_back('{0, 15000, 15000, 2, 2});
        exp_q.push_back('{2, 20000, 20000, 2, 2});
        limpa_contadores();
        pulso_inicio();
        espera_ciclo(40000, "ciclo_a");
        chk("a_fila_vazia", exp_q.size(), 0);
        chk("a_mascara", 32'(mascara), 32'b0101);
        chk("a_zona1_ciclos", za_cnt[1], 2);
        chk("a_abortada", 32'(zona_abortada), 0);

        // Cycle B: hot weather boosts zone0 by 25%
        sensor_temp   = 8'd45;
        zona_habilita = 4'b0001;
        exp_q.push_back('{0, 18750, 18750, 2, 2});
        pulso_inicio();
        espera_ciclo(20000, "ciclo_b");
        chk("b_fila_vazia", exp_q.size(), 0);

        // Cycle C: exactly 35 degrees is not hot; reset lands mid-IRRIGA
        sensor_temp = 8'd35;
        pulso_inicio();
        espera_bomba(1'b1, 20, "c_bomba_liga");
        chk("c_tempo_35", 32'(tempo_restante_ms), 15000);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("c_rst_valvula", 32'(valvula), 0);
        chk("c_rst_bomba", 32'(bomba_ligada), 0);
        chk("c_rst_ocupado", 32'(ocupado), 0);
        chk("c_rst_zona", 32'(zona_ativa), 0);
        chk("c_rst_tempo", 32'(tempo_restante_ms), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cycle D: low level skips every zone but the cycle still completes
        sensor_nivel  = 8'd10;
        zona_habilita = 4'b1111;
        repeat (2) @(negedge clk);
        chk("d_alerta_10", 32'(alerta_nivel_baixo), 1);
        limpa_contadores();
        pulso_inicio();
        espera_ciclo(100, "ciclo_d");
        chk("d_mascara", 32'(mascara), 0);
        for (int i = 0; i < N; i++) chk("d_zona_ciclos", za_cnt[i], 2);

        // Hysteresis band
        sensor_nivel = 8'd17; repeat (3) @(negedge clk);
        chk("hist_17", 32'(alerta_nivel_baixo), 1);
        sensor_nivel = 8'd20; repeat (2) @(negedge clk);
        chk("hist_20", 32'(alerta_nivel_baixo), 0);
        sensor_nivel = 8'd15; repeat (2) @(negedge clk);
        chk("hist_15", 32'(alerta_nivel_baixo), 0);
        sensor_nivel = 8'd14; repeat (2) @(negedge clk);
        chk("hist_14", 32'(alerta_nivel_baixo), 1);
        sensor_nivel = 8'd19; repeat (2) @(negedge clk);
        chk("hist_19", 32'(alerta_nivel_baixo), 1);
        sensor_nivel = 8'd80; repeat (2) @(negedge clk);
        chk("hist_80", 32'(alerta_nivel_baixo), 0);

        // Cycle E: level drops after 500 ms of zone0 pumping
        sensor_temp   = 8'd25;
        zona_habilita = 4'b0011;
        exp_q.push_back('{0, 15000, 501, 2, 2});
        limpa_contadores();
        pulso_inicio();
        espera_bomba(1'b1, 20, "e_bomba_liga");
        repeat (499) @(negedge clk);
        sensor_nivel = 8'd10;
        espera_bomba(1'b0, 10, "e_bomba_desliga");
        chk("e_tempo_residual", 32'(tempo_restante_ms), 14500);
        chk("e_abortada", 32'(zona_abortada), 32'b0001);
        chk("e_valvula_fecha", 32'(valvula), 32'b0001);
        espera_ciclo(50, "ciclo_e");
        chk("e_zona1_ciclos", za_cnt[1], 2);
        chk("e_fila_vazia", exp_q.size(), 0);
        chk("e_abortada_fixa", 32'(zona_abortada), 32'b0001);
        pulso_inicio();
        chk("e_abortada_limpa", 32'(zona_abortada), 0);
        espera_ciclo(100, "ciclo_f");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
